// File: rtl/resim_filtre_cozucu.sv
// -----------------------------------------------------------------------------
// resim_filtre_cozucu
//   Receive-side decoder for the 5-bit filter codes produced by
//   resim_filtreleyici. Each code carries a 3-bit pixel plus two check bits:
//     code[4:2] = pixel
//     code[1]   = ^pixel   (odd parity)
//     code[0]   = ~^pixel  (even parity, always the inverse of code[1])
//   A code is valid when code[1] == ^code[4:2] and code[0] != code[1].
//   Decoded pixels go through a small FIFO so the producer and consumer can
//   stall independently. Pixels are counted into frames and the final pixel of
//   each frame is tagged with out_last. Invalid codes are reported through a
//   sticky flag and a saturating counter. With ERR_HALT=1 an invalid code
//   also stops input until err_clr.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. valid never depends on ready. Data is held stable while
//   valid=1 and ready=0.
//
// Parameters
//   DEPTH      FIFO entries (power of 2, >= 2)
//   FRAME_LEN  pixels per frame (>= 1)
//   ERR_HALT   1: invalid code halts input until err_clr
//              0: store pixel 0 and keep accepting
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_code valid
//   in_ready   decoder accepts in_code this cycle
//   in_code    5-bit filter code
//   out_valid  out_pixel / out_last valid
//   out_ready  consumer accepts this cycle
//   out_pixel  decoded pixel
//   out_last   last pixel of the frame
//   err_flag   sticky: an invalid code was accepted
//   err_count  invalid codes accepted, saturates at 255
//   err_clr    clears err_flag / err_count and leaves HALT
// -----------------------------------------------------------------------------
module resim_filtre_cozucu #(
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 8,
  parameter int ERR_HALT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_pixel,
  output logic       out_last,
  output logic       err_flag,
  output logic [7:0] err_count,
  input  logic       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Each entry is {last, pixel}.
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [FW-1:0] frame_idx;

  logic       code_ok;
  logic       push, pop;
  logic       frame_last;
  logic [2:0] pixel_dec;

  assign code_ok    = (in_code[1] == ^in_code[4:2]) && (in_code[0] != in_code[1]);
  assign pixel_dec  = code_ok ? in_code[4:2] : 3'd0;
  assign frame_last = (frame_idx == FW'(FRAME_LEN - 1));

  // in_ready is forced low while rst is held so nothing is accepted into a
  // FIFO that is being cleared. No write-through: a full FIFO refuses input
  // even when a pop happens in the same cycle.
  assign in_ready  = !rst && (state == RUN) && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is gated so the outputs read 0 whenever the FIFO is empty.
  assign out_pixel = out_valid ? mem[rd_ptr][2:0] : 3'd0;
  assign out_last  = out_valid ? mem[rd_ptr][3]   : 1'b0;

  // ---------------------------------------------------------------------------
  // RUN/HALT state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (push && !code_ok && (ERR_HALT != 0)) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
    // err_clr wins over an invalid accept in the same cycle.
    if (err_clr) begin
      state_nxt = RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage (contents need no reset; out_valid gates the head)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {frame_last, pixel_dec};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame position: every accepted code, valid or not, occupies a slot.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_idx <= '0;
    end else if (push) begin
      frame_idx <= frame_last ? '0 : frame_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Error reporting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag  <= 1'b0;
      err_count <= 8'd0;
    end else if (err_clr) begin
      err_flag  <= 1'b0;
      err_count <= 8'd0;
    end else if (push && !code_ok) begin
      err_flag <= 1'b1;
      if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_resim_filtre_cozucu.sv
// -----------------------------------------------------------------------------
// tb_resim_filtre_cozucu
//   Two instances: u0 with ERR_HALT=0, u1 with ERR_HALT=1, both DEPTH=4,
//   FRAME_LEN=8. A queue-based model per instance predicts every output on
//   every cycle; directed scenarios add literal checks on the popped stream.
//   Inputs change at posedge+1; outputs and model are sampled at negedge.
// -----------------------------------------------------------------------------
module tb_resim_filtre_cozucu;

  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 8;

  logic       clk;
  logic       rst       [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [4:0] in_code   [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [2:0] out_pixel [2];
  logic       out_last  [2];
  logic       err_flag  [2];
  logic [7:0] err_count [2];
  logic       err_clr   [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // ---------------------------------------------------------------- clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- DUTs
  resim_filtre_cozucu #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN), .ERR_HALT(0)) u0 (
    .clk(clk), .rst(rst[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_code(in_code[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_pixel(out_pixel[0]), .out_last(out_last[0]),
    .err_flag(err_flag[0]), .err_count(err_count[0]), .err_clr(err_clr[0])
  );

  resim_filtre_cozucu #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN), .ERR_HALT(1)) u1 (
    .clk(clk), .rst(rst[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_code(in_code[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_pixel(out_pixel[1]), .out_last(out_last[1]),
    .err_flag(err_flag[1]), .err_count(err_count[1]), .err_clr(err_clr[1])
  );

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] enc(input logic [2:0] p);
    return {p, ^p, ~^p};
  endfunction

  function automatic bit code_ok(input logic [4:0] c);
    return (c[1] == ^c[4:2]) && (c[0] != c[1]);
  endfunction

  // ---------------------------------------------------------------- model
  // Queue entries are {last, pixel}; exp_q0/exp_q1 are the FIFO contents.
  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];
  logic [3:0] obs0[$];
  logic [3:0] obs1[$];
  int  m_fidx   [2] = '{0, 0};
  int  m_ecnt   [2] = '{0, 0};
  bit  m_eflag  [2] = '{0, 0};
  bit  m_halted [2] = '{0, 0};

  int         sz;
  logic [3:0] hd;
  bit         e_ir, e_ov, m_pop, m_acc, m_last;
  logic [2:0] m_px;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      sz   = (i == 0) ? exp_q0.size() : exp_q1.size();
      hd   = (sz == 0) ? 4'd0 : ((i == 0) ? exp_q0[0] : exp_q1[0]);
      e_ir = !rst[i] && !m_halted[i] && (sz < DEPTH);
      e_ov = (sz > 0);
      if (chk_en) begin
        chk($sformatf("u%0d in_ready", i),  {31'd0, in_ready[i]},  {31'd0, e_ir});
        chk($sformatf("u%0d out_valid", i), {31'd0, out_valid[i]}, {31'd0, e_ov});
        chk($sformatf("u%0d out_pixel", i), {29'd0, out_pixel[i]}, {29'd0, hd[2:0]});
        chk($sformatf("u%0d out_last", i),  {31'd0, out_last[i]},  {31'd0, hd[3]});
        chk($sformatf("u%0d err_flag", i),  {31'd0, err_flag[i]},  {31'd0, m_eflag[i]});
        chk($sformatf("u%0d err_count", i), {24'd0, err_count[i]}, m_ecnt[i]);
        if (out_valid[i] === 1'b1 && out_ready[i]) begin
          if (i == 0) obs0.push_back({out_last[i], out_pixel[i]});
          else        obs1.push_back({out_last[i], out_pixel[i]});
        end
      end
      // Advance the model to what the coming rising edge must produce.
      m_pop = e_ov && out_ready[i];
      m_acc = in_valid[i] && e_ir;
      if (rst[i]) begin
        if (i == 0) exp_q0.delete(); else exp_q1.delete();
        m_fidx[i] = 0; m_ecnt[i] = 0; m_eflag[i] = 0; m_halted[i] = 0;
      end else begin
        if (m_pop) begin
          if (i == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
        end
        if (m_acc) begin
          m_px   = code_ok(in_code[i]) ? in_code[i][4:2] : 3'd0;
          m_last = (m_fidx[i] == FRAME_LEN - 1);
          if (i == 0) exp_q0.push_back({m_last, m_px}); else exp_q1.push_back({m_last, m_px});
          m_fidx[i] = m_last ? 0 : m_fidx[i] + 1;
          if (!code_ok(in_code[i])) begin
            m_eflag[i] = 1;
            if (m_ecnt[i] < 255) m_ecnt[i]++;
            if (i == 1) m_halted[i] = 1;
          end
        end
        if (err_clr[i]) begin
          m_eflag[i] = 0; m_ecnt[i] = 0; m_halted[i] = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a code until it is accepted; bounded wait.
  task automatic send(input int i, input logic [4:0] c);
    bit done;
    done = 0;
    in_valid[i] = 1'b1;
    in_code[i]  = c;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready[i] === 1'b1) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL u%0d accept timeout: code %b not accepted", i, c);
    end
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; in_code[i] = 5'd0;
      out_ready[i] = 1'b1; err_clr[i] = 1'b0;
    end
    tick(1);
    chk_en = 1;
    tick(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("reset err_count", {24'd0, err_count[0]}, 32'd0);
    chk("reset out_valid", {31'd0, out_valid[0]}, 32'd0);
    tick(1);

    // 1: one frame, 7 down to 0, consumer always ready.
    obs0.delete();
    for (int p = 7; p >= 0; p--) send(0, enc(3'(p)));
    tick(2);
    chk("t1 count", obs0.size(), 32'd8);
    for (int k = 0; k < 8 && k < obs0.size(); k++)
      chk($sformatf("t1 item%0d", k), {28'd0, obs0[k]}, {28'd0, (k == 7), 3'(7 - k)});

    // 2: fill the FIFO with the consumer stalled, then release it.
    obs0.delete();
    out_ready[0] = 1'b0;
    for (int p = 1; p <= 4; p++) send(0, enc(3'(p)));
    @(negedge clk);
    chk("t2 full in_ready", {31'd0, in_ready[0]}, 32'd0);
    tick(1);
    fork
      send(0, enc(3'd5));
      begin
        tick(2);
        out_ready[0] = 1'b1;
      end
    join
    tick(3);
    chk("t2 count", obs0.size(), 32'd5);
    for (int k = 0; k < 5 && k < obs0.size(); k++)
      chk($sformatf("t2 pix%0d", k), {29'd0, obs0[k][2:0]}, 32'(k + 1));

    // 3: invalid code in stream (frame index 5,6,7,0). 5'b11101 fails the
    //    parity test; 5'b11110 satisfies the rule and decodes to 7.
    obs0.delete();
    send(0, enc(3'd2));
    send(0, 5'b11101);
    send(0, 5'b11110);
    send(0, enc(3'd6));
    tick(3);
    chk("t3 count", obs0.size(), 32'd4);
    if (obs0.size() == 4) begin
      chk("t3 s0", {28'd0, obs0[0]}, 32'h2);
      chk("t3 s1", {28'd0, obs0[1]}, 32'h0);
      chk("t3 s2", {28'd0, obs0[2]}, 32'hf);
      chk("t3 s3", {28'd0, obs0[3]}, 32'h6);
    end
    @(negedge clk);
    chk("t3 err_flag", {31'd0, err_flag[0]}, 32'd1);
    chk("t3 err_count", {24'd0, err_count[0]}, 32'd1);
    tick(1);

    // 4: halting instance.
    obs1.delete();
    send(1, enc(3'd3));
    send(1, 5'b00011);
    fork
      begin
        send(1, enc(3'd4));
        send(1, enc(3'd5));
      end
      begin
        repeat (4) begin
          @(negedge clk);
          chk("t4 halt in_ready", {31'd0, in_ready[1]}, 32'd0);
        end
        tick(1);
        err_clr[1] = 1'b1;
        tick(1);
        err_clr[1] = 1'b0;
      end
    join
    tick(3);
    chk("t4 count", obs1.size(), 32'd4);
    if (obs1.size() == 4) begin
      chk("t4 s0", {29'd0, obs1[0][2:0]}, 32'd3);
      chk("t4 s1", {29'd0, obs1[1][2:0]}, 32'd0);
      chk("t4 s2", {29'd0, obs1[2][2:0]}, 32'd4);
      chk("t4 s3", {29'd0, obs1[3][2:0]}, 32'd5);
    end
    @(negedge clk);
    chk("t4 err_flag", {31'd0, err_flag[1]}, 32'd0);
    tick(1);

    // 5: reset with three pixels buffered.
    out_ready[0] = 1'b0;
    for (int p = 1; p <= 3; p++) send(0, enc(3'(p)));
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    @(negedge clk);
    chk("t5 out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("t5 err_count", {24'd0, err_count[0]}, 32'd0);
    tick(1);
    out_ready[0] = 1'b1;
    obs0.delete();
    for (int p = 0; p < 8; p++) send(0, enc(3'(p)));
    tick(2);
    chk("t5 count", obs0.size(), 32'd8);
    for (int k = 0; k < 8 && k < obs0.size(); k++)
      chk($sformatf("t5 last%0d", k), {31'd0, obs0[k][3]}, {31'd0, (k == 7)});

    // 6: counter saturation, then clear racing an invalid accept.
    for (int k = 0; k < 256; k++) send(0, 5'b00011);
    @(negedge clk);
    chk("t6 sat count", {24'd0, err_count[0]}, 32'd255);
    chk("t6 sat flag", {31'd0, err_flag[0]}, 32'd1);
    tick(1);
    err_clr[0] = 1'b1;
    send(0, 5'b00011);
    err_clr[0] = 1'b0;
    @(negedge clk);
    chk("t6 clr count", {24'd0, err_count[0]}, 32'd0);
    chk("t6 clr flag", {31'd0, err_flag[0]}, 32'd0);
    tick(3);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
